xnor_gate: RTL and testbench
============================

Name: xnor_gate

Overview:
Bitwise XNOR (equality) block with a combinational result path plus a registered, valid-qualified result path with match statistics.
- Combinational output y = a XNOR b serves glue logic that samples without a clock.
- Registered outputs feed compare/checker logic downstream: result, all-bits-equal flag, matching-bit count, sticky mismatch flag.
- Single clock domain.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).
- CNT_W, $clog2(WIDTH+1), width of match_cnt_q. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_valid  input  1  a/b qualify for the registered path this cycle
- clr  input  1  synchronous clear of the sticky flag and registered outputs
- y  output  WIDTH  combinational ~(a ^ b)
- y_q  output  WIDTH  registered XNOR result
- out_valid  output  1  y_q / eq_q / match_cnt_q updated last edge
- eq_q  output  1  registered (a == b), i.e. &y
- match_cnt_q  output  CNT_W  registered popcount of y
- mismatch_seen  output  1  sticky: some valid sample had a != b
- parity_q  output  1  registered ^y (see Optional Feature)

Behaviour:
- y = ~(a ^ b) at all times: purely combinational, zero latency, independent of clk, rst_n, in_valid and clr. X/Z on an input bit propagates X only to that bit.
- Reset (rst_n low, asynchronous assert; deassert synchronised by the user):
  - y_q = 0, out_valid = 0, eq_q = 0, match_cnt_q = 0, mismatch_seen = 0, parity_q = 0.
  - y still tracks its inputs during reset.
- Rising clk with rst_n high, priority order:
  - clr = 1: out_valid, y_q, eq_q, match_cnt_q, parity_q and mismatch_seen all go to 0. clr has priority over in_valid.
  - else in_valid = 1:
    - y_q <= ~(a ^ b), eq_q <= (a == b), match_cnt_q <= popcount(~(a ^ b)), out_valid <= 1.
    - mismatch_seen <= mismatch_seen | (a != b).
  - else: out_valid <= 0; y_q, eq_q, match_cnt_q and parity_q hold; mismatch_seen holds.
- Latency: one cycle from in_valid to out_valid. Back-to-back valid every cycle is supported. No backpressure.
- match_cnt_q range is 0..WIDTH. With WIDTH = 1, CNT_W = 1 and match_cnt_q == y_q.
- Reset asserted mid-stream clears everything immediately. The first valid after reset release produces out_valid on the following edge.

Optional Feature:
- Macro XNOR_GATE_PARITY_EN.
- Defined: parity_q registers ^(~(a ^ b)) under the same clr/in_valid/hold rules as y_q.
- Undefined: parity_q is tied to constant 0 and no parity logic is built. The port exists in both builds.

Test Plan:
- WIDTH=1, combinational truth table:
  - drive (a,b) = 00, 01, 10, 11 at 10 ns intervals; sample 10 ns after each change.
  - required y = 1, 0, 0, 1.
  - write each "a=%b, b=%b, y=%b @ t ns" line to monitor_log.txt and dump a VCD.
- WIDTH=1, registered path:
  - same four pairs with in_valid = 1 on consecutive cycles.
  - required next-cycle y_q = 1, 0, 0, 1 and eq_q = 1, 0, 0, 1 with out_valid = 1.
  - mismatch_seen goes to 1 after the 01 sample and stays 1.
- WIDTH=8:
  - a = 8'hF0, b = 8'hF0 -> y = 8'hFF, eq_q = 1, match_cnt_q = 8.
  - a = 8'hAA, b = 8'h55 -> y = 8'h00, eq_q = 0, match_cnt_q = 0.
  - a = 8'h0F, b = 8'h03 -> y = 8'hF3, match_cnt_q = 6.
- Hold/clear:
  - in_valid = 0 -> out_valid = 0, y_q holds.
  - clr = 1 together with in_valid = 1 -> all registered outputs and mismatch_seen go to 0.
- Async reset:
  - drop rst_n between clock edges -> registered outputs go to 0 immediately.
  - y keeps following a and b (a = 1, b = 1 gives y = 1).
- Parity: WIDTH=8, a = 8'h0F, b = 8'h03.
  - with XNOR_GATE_PARITY_EN defined -> parity_q = 0 (six ones).
  - without it -> parity_q = 0 for all stimulus, including a = 8'h01, b = 8'h00.

Source files
------------

// File: rtl/xnor_gate_if.sv
// xnor_gate_if: operand/control and result bundle for xnor_gate.
// The master drives operands and controls. The slave (xnor_gate) drives all results.
interface xnor_gate_if #(
   parameter int WIDTH = 1
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic             clr;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_q;
   logic             out_valid;
   logic             eq_q;
   logic [CNT_W-1:0] match_cnt_q;
   logic             mismatch_seen;
   logic             parity_q;

   modport master (
      output a, b, in_valid, clr,
      input  y, y_q, out_valid, eq_q, match_cnt_q, mismatch_seen, parity_q
   );

   modport slave (
      input  a, b, in_valid, clr,
      output y, y_q, out_valid, eq_q, match_cnt_q, mismatch_seen, parity_q
   );
endinterface

// File: rtl/xnor_gate.sv
// xnor_gate: bitwise XNOR with a combinational path and a registered, valid-qualified path with match statistics.
// Define XNOR_GATE_PARITY_EN to build the registered parity output; otherwise parity_q is tied to 0.
module xnor_gate #(
   parameter int WIDTH = 1
) (
   input logic        clk,
   input logic        rst_n,
   xnor_gate_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] xnor_w;
   logic [CNT_W-1:0] pop_w;
   logic [WIDTH-1:0] y_r;
   logic             ov_r;
   logic             eq_r;
   logic             ms_r;
   logic [CNT_W-1:0] cnt_r;

   assign xnor_w = ~(bus.a ^ bus.b);
   assign bus.y  = xnor_w;

   always_comb begin
      pop_w = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pop_w = pop_w + CNT_W'(xnor_w[i]);
      end
   end

   // clr outranks in_valid; with neither, only out_valid drops and results hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_r   <= '0;
         ov_r  <= 1'b0;
         eq_r  <= 1'b0;
         cnt_r <= '0;
         ms_r  <= 1'b0;
      end else if (bus.clr) begin
         y_r   <= '0;
         ov_r  <= 1'b0;
         eq_r  <= 1'b0;
         cnt_r <= '0;
         ms_r  <= 1'b0;
      end else if (bus.in_valid) begin
         y_r   <= xnor_w;
         ov_r  <= 1'b1;
         eq_r  <= &xnor_w;
         cnt_r <= pop_w;
         ms_r  <= ms_r | ~(&xnor_w);
      end else begin
         ov_r  <= 1'b0;
      end
   end

   assign bus.y_q           = y_r;
   assign bus.out_valid     = ov_r;
   assign bus.eq_q          = eq_r;
   assign bus.match_cnt_q   = cnt_r;
   assign bus.mismatch_seen = ms_r;

`ifdef XNOR_GATE_PARITY_EN
   logic par_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_r <= 1'b0;
      end else if (bus.clr) begin
         par_r <= 1'b0;
      end else if (bus.in_valid) begin
         par_r <= ^xnor_w;
      end
   end

   assign bus.parity_q = par_r;
`else
   assign bus.parity_q = 1'b0;
`endif
endmodule

// File: tb/tb_xnor_gate.sv
// tb_xnor_gate: scoreboard bench driving a WIDTH=1 and a WIDTH=8 xnor_gate with directed and random stimulus.
// Expected results come from a bit-equality model; a monitor per instance pops and compares on out_valid.
module tb_xnor_gate;
   typedef struct {
      logic [7:0] y;
      logic       eq;
      int         cnt;
      logic       par;
      logic       ms;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q1[$];
   exp_t q8[$];
   logic ms1 = 1'b0;
   logic ms8 = 1'b0;

   always #5 clk = ~clk;

   xnor_gate_if #(.WIDTH(1)) bus1 ();
   xnor_gate_if #(.WIDTH(8)) bus8 ();

   xnor_gate #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   xnor_gate #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   // Reference: a result bit is 1 where the operand bits are equal; statistics follow from that.
   function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input int unsigned w);
      exp_t e;
      e.y   = 8'h00;
      e.eq  = 1'b1;
      e.cnt = 0;
      e.ms  = 1'b0;
      for (int unsigned i = 0; i < w; i++) begin
         if (av[i] == bv[i]) begin
            e.y[i] = 1'b1;
            e.cnt++;
         end else begin
            e.eq = 1'b0;
         end
      end
`ifdef XNOR_GATE_PARITY_EN
      e.par = (e.cnt % 2 == 1);
`else
      e.par = 1'b0;
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h @ %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_out(input string tag, input exp_t e, input logic [7:0] yq, input logic eq,
                          input int cnt, input logic par, input logic ms);
      chk({tag, "_y_q"}, 64'(yq), 64'(e.y));
      chk({tag, "_eq_q"}, 64'(eq), 64'(e.eq));
      chk({tag, "_match_cnt_q"}, 64'(cnt), 64'(e.cnt));
      chk({tag, "_parity_q"}, 64'(par), 64'(e.par));
      chk({tag, "_mismatch_seen"}, 64'(ms), 64'(e.ms));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_w1_out_valid"}, 64'(bus1.out_valid), 64'd0);
      chk({tag, "_w8_out_valid"}, 64'(bus8.out_valid), 64'd0);
      chk({tag, "_w1_y_q"}, 64'(bus1.y_q), 64'd0);
      chk({tag, "_w8_y_q"}, 64'(bus8.y_q), 64'd0);
      chk({tag, "_w8_eq_q"}, 64'(bus8.eq_q), 64'd0);
      chk({tag, "_w8_match_cnt_q"}, 64'(bus8.match_cnt_q), 64'd0);
      chk({tag, "_w1_mismatch_seen"}, 64'(bus1.mismatch_seen), 64'd0);
      chk({tag, "_w8_mismatch_seen"}, 64'(bus8.mismatch_seen), 64'd0);
      chk({tag, "_w8_parity_q"}, 64'(bus8.parity_q), 64'd0);
   endtask

   // Drive one cycle of stimulus to both instances (WIDTH=1 sees bit 0) and queue expectations.
   task automatic step(input logic [7:0] av, input logic [7:0] bv, input logic v, input logic c);
      exp_t e1;
      exp_t e8;
      @(negedge clk);
      bus1.a = av[0];  bus1.b = bv[0];  bus1.in_valid = v;  bus1.clr = c;
      bus8.a = av;     bus8.b = bv;     bus8.in_valid = v;  bus8.clr = c;
      e1 = model(av, bv, 1);
      e8 = model(av, bv, 8);
      if (c) begin
         ms1 = 1'b0;
         ms8 = 1'b0;
      end else if (v) begin
         ms1 = ms1 | ~e1.eq;
         ms8 = ms8 | ~e8.eq;
         e1.ms = ms1;
         e8.ms = ms8;
         q1.push_back(e1);
         q8.push_back(e8);
      end
      #1;
      chk("w1_y_comb", 64'(bus1.y), 64'(e1.y[0]));
      chk("w8_y_comb", 64'(bus8.y), 64'(e8.y));
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus1.out_valid) begin
            if (q1.size() == 0) chk("w1_queue_depth", 64'(q1.size()), 64'd1);
            else begin
               e = q1.pop_front();
               chk_out("w1", e, {7'd0, bus1.y_q}, bus1.eq_q, int'(bus1.match_cnt_q),
                       bus1.parity_q, bus1.mismatch_seen);
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus8.out_valid) begin
            if (q8.size() == 0) chk("w8_queue_depth", 64'(q8.size()), 64'd1);
            else begin
               e = q8.pop_front();
               chk_out("w8", e, bus8.y_q, bus8.eq_q, int'(bus8.match_cnt_q),
                       bus8.parity_q, bus8.mismatch_seen);
            end
         end
      end
   end

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      exp_t       eh;
      bus1.a = '0; bus1.b = '0; bus1.in_valid = 1'b0; bus1.clr = 1'b0;
      bus8.a = '0; bus8.b = '0; bus8.in_valid = 1'b0; bus8.clr = 1'b0;

      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Truth-table pairs on consecutive cycles; sticky flag rises on the 01 sample.
      step(8'h00, 8'h00, 1'b1, 1'b0);
      step(8'h00, 8'h01, 1'b1, 1'b0);
      step(8'h01, 8'h00, 1'b1, 1'b0);
      step(8'h01, 8'h01, 1'b1, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b0);

      step(8'hF0, 8'hF0, 1'b1, 1'b0);
      step(8'hAA, 8'h55, 1'b1, 1'b0);
      step(8'h0F, 8'h03, 1'b1, 1'b0);
      step(8'h01, 8'h00, 1'b1, 1'b0);

      // Hold: results from 01/00 persist while out_valid drops.
      step(8'h12, 8'h34, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      eh = model(8'h01, 8'h00, 8);
      chk("hold_w8_out_valid", 64'(bus8.out_valid), 64'd0);
      chk("hold_w8_y_q", 64'(bus8.y_q), 64'(eh.y));
      chk("hold_w8_match_cnt_q", 64'(bus8.match_cnt_q), 64'(eh.cnt));
      chk("hold_w8_parity_q", 64'(bus8.parity_q), 64'(eh.par));
      chk("hold_w1_y_q", 64'(bus1.y_q), 64'd0);
      chk("hold_w8_mismatch_seen", 64'(bus8.mismatch_seen), 64'd1);

      step(8'hAA, 8'hAA, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk_zero("clr");

      for (int n = 0; n < 300; n++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
         step(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end
      repeat (3) step(8'h00, 8'h00, 1'b0, 1'b0);
      chk("drain_w1_queue", 64'(q1.size()), 64'd0);
      chk("drain_w8_queue", 64'(q8.size()), 64'd0);

      // Asynchronous reset between edges.
      @(negedge clk);
      bus1.a = 1'b1;  bus1.b = 1'b1;  bus1.in_valid = 1'b0;  bus1.clr = 1'b0;
      bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.in_valid = 1'b0;  bus8.clr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      chk("rst_w1_y_comb", 64'(bus1.y), 64'd1);
      chk("rst_w8_y_comb", 64'(bus8.y), 64'hFF);
      q1.delete();
      q8.delete();
      ms1 = 1'b0;
      ms8 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      step(8'h0F, 8'h03, 1'b1, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b0);
      chk("post_reset_w1_queue", 64'(q1.size()), 64'd0);
      chk("post_reset_w8_queue", 64'(q8.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
